// File: rtl/gimli_permutation_iterative.sv
// Iterative Gimli-384 permutation core.
// Each busy cycle applies the SP-box to COLUMNS_PER_CYCLE columns (1, 2 or 4).
// The round's swap and constant step is folded into the cycle that finishes
// the last column group of that round.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for din_valid; din_ready is high
// BUSY  | running 24 rounds, one column group per clock
// DONE  | result held on dout until dout_ready
module gimli_permutation_iterative #(
    parameter int COLUMNS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic [383:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [383:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready
);

    localparam int         NUM_GROUPS = 4 / COLUMNS_PER_CYCLE;
    localparam logic [1:0] LAST_GROUP = 2'(NUM_GROUPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   fsm_q, fsm_d;
    logic [383:0] state_q, state_d;
    logic [4:0]   round_q, round_d;
    logic [1:0]   group_q, group_d;

    logic [383:0] sp_state;
    logic [383:0] round_state;
    logic [1:0]   col;
    logic [31:0]  x, y, z;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // SP-box on the columns of the current group; other columns pass through
    always_comb begin
        sp_state = state_q;
        col      = '0;
        x        = '0;
        y        = '0;
        z        = '0;
        for (int j = 0; j < COLUMNS_PER_CYCLE; j++) begin
            col = 2'(int'(group_q) * COLUMNS_PER_CYCLE + j);
            x   = rotl(state_q[32*col +: 32], 24);
            y   = rotl(state_q[32*(4+col) +: 32], 9);
            z   = state_q[32*(8+col) +: 32];
            sp_state[32*(8+col) +: 32] = x ^ (z << 1) ^ ((y & z) << 2);
            sp_state[32*(4+col) +: 32] = y ^ x ^ ((x | z) << 1);
            sp_state[32*col +: 32]     = z ^ y ^ ((x & y) << 3);
        end
    end

    // End-of-round linear layer: row-0 swaps and round constant
    always_comb begin
        round_state = sp_state;
        case (round_q[1:0])
            2'd0: begin
                round_state[31:0]   = sp_state[63:32] ^ 32'h9E37_7900 ^ {27'd0, round_q};
                round_state[63:32]  = sp_state[31:0];
                round_state[95:64]  = sp_state[127:96];
                round_state[127:96] = sp_state[95:64];
            end
            2'd2: begin
                round_state[31:0]   = sp_state[95:64];
                round_state[95:64]  = sp_state[31:0];
                round_state[63:32]  = sp_state[127:96];
                round_state[127:96] = sp_state[63:32];
            end
            default: ;
        endcase
    end

    // Next-state logic for FSM, state register and round/group counters
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        group_d = group_q;
        case (fsm_q)
            IDLE: begin
                if (din_valid) begin
                    state_d = din;
                    round_d = 5'd24;
                    group_d = 2'd0;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                if (group_q == LAST_GROUP) begin
                    state_d = round_state;
                    round_d = round_q - 5'd1;
                    group_d = 2'd0;
                    if (round_q == 5'd1) fsm_d = DONE;
                end else begin
                    state_d = sp_state;
                    group_d = group_q + 2'd1;
                end
            end
            DONE: begin
                if (dout_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= 5'd24;
            group_q <= 2'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            group_q <= group_d;
        end
    end

    assign din_ready  = (fsm_q == IDLE);
    assign dout_valid = (fsm_q == DONE);
    assign dout       = state_q;

endmodule

// File: tb/tb_gimli_permutation_iterative.sv
// Bench for gimli_permutation_iterative: one instance per column width
// (1, 2, 4) against a plain software-style Gimli model.
module tb_gimli_permutation_iterative;

    localparam int LIMIT = 300;

    logic         clk;
    logic         arstn;
    logic [383:0] din        [3];
    logic         din_valid  [3];
    logic         din_ready  [3];
    logic [383:0] dout       [3];
    logic         dout_valid [3];
    logic         dout_ready [3];

    int vectors     = 0;
    int miscompares = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gimli_permutation_iterative #(
            .COLUMNS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))
        ) u_dut (
            .clk       (clk),
            .arstn     (arstn),
            .din       (din[g]),
            .din_valid (din_valid[g]),
            .din_ready (din_ready[g]),
            .dout      (dout[g]),
            .dout_valid(dout_valid[g]),
            .dout_ready(dout_ready[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    // Reference Gimli permutation, written as the textbook loop
    function automatic logic [383:0] gimli_ref(input logic [383:0] in);
        logic [31:0] s [12];
        logic [31:0] x, y, z, t;
        logic [383:0] out;
        for (int i = 0; i < 12; i++) s[i] = in[32*i +: 32];
        for (int r = 24; r > 0; r--) begin
            for (int c = 0; c < 4; c++) begin
                x = {s[c][7:0], s[c][31:8]};
                y = {s[4+c][22:0], s[4+c][31:23]};
                z = s[8+c];
                s[8+c] = x ^ {z[30:0], 1'b0} ^ {(y[29:0] & z[29:0]), 2'b00};
                s[4+c] = y ^ x ^ {(x[30:0] | z[30:0]), 1'b0};
                s[c]   = z ^ y ^ {(x[28:0] & y[28:0]), 3'b000};
            end
            if (r % 4 == 0) begin
                t = s[0]; s[0] = s[1]; s[1] = t;
                t = s[2]; s[2] = s[3]; s[3] = t;
                s[0] = s[0] ^ 32'h9E37_7900 ^ 32'(r);
            end else if (r % 4 == 2) begin
                t = s[0]; s[0] = s[2]; s[2] = t;
                t = s[1]; s[1] = s[3]; s[3] = t;
            end
        end
        for (int i = 0; i < 12; i++) out[32*i +: 32] = s[i];
        return out;
    endfunction

    function automatic logic [383:0] kat_in();
        logic [383:0] v;
        logic [31:0]  iv;
        for (int i = 0; i < 12; i++) begin
            iv = 32'(i);
            v[32*i +: 32] = iv * iv * iv + iv * 32'h9E37_79B9;
        end
        return v;
    endfunction

    function automatic logic [383:0] rand384();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int k, output int n);
        n = 0;
        while (dout_valid[k] !== 1'b1 && n < LIMIT) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [383:0] rin [3];
        int n;
        arstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din[k] = '0; din_valid[k] = 1'b0; dout_ready[k] = 1'b0;
        end
        #3;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (din_ready[k] !== 1'b1 || dout_valid[k] !== 1'b0 || dout[k] !== '0) begin
                miscompares++;
                $display("FAIL reset_state C=%0d: ready=%b valid=%b dout=%h, expected 1 0 0",
                         cpc(k), din_ready[k], dout_valid[k], dout[k]);
            end
        end
        step();
        for (int k = 0; k < 3; k++) begin
            rin[k] = rand384(); din[k] = rin[k]; din_valid[k] = 1'b1;
        end
        arstn = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            din_valid[k] = 1'b0;
            vectors++;
            if (din_ready[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL first_edge_accept C=%0d: din_ready=%b expected 0", cpc(k), din_ready[k]);
            end
        end
        n = 0;
        while (!(dout_valid[0] === 1'b1 && dout_valid[1] === 1'b1 && dout_valid[2] === 1'b1) && n < LIMIT) begin
            step();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (dout_valid[k] !== 1'b1 || dout[k] !== gimli_ref(rin[k])) begin
                miscompares++;
                $display("FAIL random_result C=%0d: valid=%b got %h expected %h",
                         cpc(k), dout_valid[k], dout[k], gimli_ref(rin[k]));
            end
            dout_ready[k] = 1'b1;
        end
        step();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (din_ready[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL release_after_parallel C=%0d: din_ready=%b expected 1", cpc(k), din_ready[k]);
            end
        end
    endtask

    task automatic test_kat(input int k);
        logic [383:0] exp;
        int n;
        bit busy_ok;
        exp = gimli_ref(kat_in());
        dout_ready[k] = 1'b1;
        din[k] = kat_in();
        din_valid[k] = 1'b1;
        step();
        din_valid[k] = 1'b0;
        din[k] = '0;
        busy_ok = 1'b1;
        n = 0;
        while (dout_valid[k] !== 1'b1 && n < LIMIT) begin
            if (din_ready[k] !== 1'b0) busy_ok = 1'b0;
            step();
            n++;
        end
        if (din_ready[k] !== 1'b0) busy_ok = 1'b0;
        vectors++;
        if (n != 96 / cpc(k)) begin
            miscompares++;
            $display("FAIL latency C=%0d: %0d edges, expected %0d", cpc(k), n, 96 / cpc(k));
        end
        vectors++;
        if (!busy_ok) begin
            miscompares++;
            $display("FAIL din_ready_busy C=%0d: din_ready seen 1, expected 0 until release", cpc(k));
        end
        vectors++;
        if (dout[k] !== exp) begin
            miscompares++;
            $display("FAIL kat_result C=%0d: got %h expected %h", cpc(k), dout[k], exp);
        end
        vectors++;
        if (dout[k][31:0] !== 32'hBA11_C85A) begin
            miscompares++;
            $display("FAIL kat_word0 C=%0d: got %h expected ba11c85a", cpc(k), dout[k][31:0]);
        end
        step();
        vectors++;
        if (din_ready[k] !== 1'b1 || dout_valid[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL kat_release C=%0d: ready=%b valid=%b expected 1 0",
                     cpc(k), din_ready[k], dout_valid[k]);
        end
    endtask

    task automatic test_backpressure(input int k);
        logic [383:0] rin, cap;
        int n;
        rin = rand384();
        dout_ready[k] = 1'b0;
        din[k] = rin;
        din_valid[k] = 1'b1;
        step();
        din_valid[k] = 1'b0;
        wait_valid(k, n);
        cap = dout[k];
        vectors++;
        if (dout_valid[k] !== 1'b1 || cap !== gimli_ref(rin)) begin
            miscompares++;
            $display("FAIL bp_result C=%0d: valid=%b got %h expected %h",
                     cpc(k), dout_valid[k], cap, gimli_ref(rin));
        end
        for (int i = 0; i < 10; i++) begin
            din_valid[k] = i[0];
            din[k] = rand384();
            step();
            vectors++;
            if (dout_valid[k] !== 1'b1 || dout[k] !== gimli_ref(rin)) begin
                miscompares++;
                $display("FAIL bp_hold C=%0d cycle %0d: valid=%b dout=%h expected 1 %h",
                         cpc(k), i, dout_valid[k], dout[k], gimli_ref(rin));
            end
        end
        din_valid[k] = 1'b0;
        dout_ready[k] = 1'b1;
        step();
        vectors++;
        if (din_ready[k] !== 1'b1 || dout_valid[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release C=%0d: ready=%b valid=%b expected 1 0",
                     cpc(k), din_ready[k], dout_valid[k]);
        end
    endtask

    task automatic test_ignored(input int k);
        logic [383:0] exp;
        int n;
        exp = gimli_ref(kat_in());
        dout_ready[k] = 1'b1;
        din[k] = kat_in();
        din_valid[k] = 1'b1;
        step();
        din_valid[k] = 1'b0;
        n = 0;
        while (dout_valid[k] !== 1'b1 && n < LIMIT) begin
            din_valid[k] = ~din_valid[k];
            din[k] = rand384();
            dout_ready[k] = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        din_valid[k] = 1'b0;
        dout_ready[k] = 1'b1;
        vectors++;
        if (dout_valid[k] !== 1'b1 || dout[k] !== exp) begin
            miscompares++;
            $display("FAIL ignored_input C=%0d: valid=%b got %h expected %h",
                     cpc(k), dout_valid[k], dout[k], exp);
        end
        step();
        vectors++;
        if (din_ready[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_release C=%0d: din_ready=%b expected 1", cpc(k), din_ready[k]);
        end
    endtask

    task automatic test_reset_mid(input int k);
        dout_ready[k] = 1'b1;
        din[k] = rand384();
        din_valid[k] = 1'b1;
        step();
        din_valid[k] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        arstn = 1'b0;
        #1;
        vectors++;
        if (dout[k] !== '0 || din_ready[k] !== 1'b1 || dout_valid[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset C=%0d: dout=%h ready=%b valid=%b expected 0 1 0",
                     cpc(k), dout[k], din_ready[k], dout_valid[k]);
        end
        step();
        arstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dout_valid[k] !== 1'b0 || din_ready[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset_idle C=%0d: valid=%b ready=%b expected 0 1",
                         cpc(k), dout_valid[k], din_ready[k]);
            end
        end
        test_kat(k);
    endtask

    task automatic test_back_to_back(input int k);
        logic [383:0] exp0, exp1;
        int n;
        exp0 = gimli_ref('0);
        exp1 = gimli_ref(kat_in());
        dout_ready[k] = 1'b1;
        din[k] = '0;
        din_valid[k] = 1'b1;
        step();
        din[k] = kat_in();
        wait_valid(k, n);
        vectors++;
        if (dout_valid[k] !== 1'b1 || dout[k] !== exp0) begin
            miscompares++;
            $display("FAIL b2b_first C=%0d: valid=%b got %h expected %h",
                     cpc(k), dout_valid[k], dout[k], exp0);
        end
        step();
        vectors++;
        if (din_ready[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_release C=%0d: din_ready=%b expected 1", cpc(k), din_ready[k]);
        end
        step();
        vectors++;
        if (din_ready[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept C=%0d: din_ready=%b expected 0", cpc(k), din_ready[k]);
        end
        wait_valid(k, n);
        din_valid[k] = 1'b0;
        vectors++;
        if (n != 96 / cpc(k)) begin
            miscompares++;
            $display("FAIL b2b_latency C=%0d: %0d edges, expected %0d", cpc(k), n, 96 / cpc(k));
        end
        vectors++;
        if (dout_valid[k] !== 1'b1 || dout[k] !== exp1) begin
            miscompares++;
            $display("FAIL b2b_second C=%0d: valid=%b got %h expected %h",
                     cpc(k), dout_valid[k], dout[k], exp1);
        end
        step();
    endtask

    initial begin
        test_reset();
        for (int k = 0; k < 3; k++) begin
            test_kat(k);
            test_backpressure(k);
            test_ignored(k);
            test_reset_mid(k);
            test_back_to_back(k);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
